// File: rtl/fixed_arith_seq_if.sv
// Start/busy/done handshake bundle for the sequential fixed-point arithmetic unit.
// W is the operand/result width (INT_W + FRAC_W of the attached unit).
interface fixed_arith_seq_if #(
  parameter int W = 16
);
  logic         start;
  logic         op;
  logic [W-1:0] num1;
  logic [W-1:0] num2;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         overflow;

  modport master (
    output start, op, num1, num2,
    input  busy, done, result, overflow
  );

  modport slave (
    input  start, op, num1, num2,
    output busy, done, result, overflow
  );
endinterface

// File: rtl/fixed_arith_seq.sv
// Unsigned INT_W.FRAC_W fixed-point unit: single-cycle add or shift-add multiply
// (one multiplier bit per clock), with optional clamp-to-all-ones on overflow.
module fixed_arith_seq #(
  parameter int INT_W    = 8,
  parameter int FRAC_W   = 8,
  parameter int SATURATE = 0
) (
  input  logic               clk,
  input  logic               rst,
  fixed_arith_seq_if.slave   bus
);
  localparam int W  = INT_W + FRAC_W;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic [2*W-1:0]   acc_r;
  logic [W-1:0]     a_r;
  logic [W-1:0]     b_r;
  logic [W-1:0]     result_r;
  logic             overflow_r;
  logic             busy_r;
  logic             done_r;

  logic [2*W-1:0]   addend_s;
  logic [2*W-1:0]   acc_next_s;
  logic [W:0]       sum_s;
  logic [W-1:0]     mul_raw_s;
  logic             mul_ovf_s;

  function automatic logic [W-1:0] sat_fn(input logic [W-1:0] raw, input logic ovf);
    logic [W-1:0] res;
    if ((SATURATE != 0) && ovf) begin
      res = {W{1'b1}};
    end else begin
      res = raw;
    end
    return res;
  endfunction

  // Partial-product step and adder; the product window drops FRAC_W low bits.
  always_comb begin
    addend_s = {(2*W){1'b0}};
    if (b_r[cnt_r]) begin
      addend_s = {{W{1'b0}}, a_r} << cnt_r;
    end else begin
      addend_s = {(2*W){1'b0}};
    end
    acc_next_s = acc_r + addend_s;
    sum_s      = {1'b0, bus.num1} + {1'b0, bus.num2};
    mul_raw_s  = acc_next_s[W+FRAC_W-1:FRAC_W];
    mul_ovf_s  = |acc_next_s[2*W-1:W+FRAC_W];
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= {CW{1'b0}};
      acc_r      <= {(2*W){1'b0}};
      a_r        <= {W{1'b0}};
      b_r        <= {W{1'b0}};
      result_r   <= {W{1'b0}};
      overflow_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            a_r    <= bus.num1;
            b_r    <= bus.num2;
            busy_r <= 1'b1;
            if (!bus.op) begin
              result_r   <= sat_fn(sum_s[W-1:0], sum_s[W]);
              overflow_r <= sum_s[W];
              done_r     <= 1'b1;
              state_r    <= DONE;
            end else begin
              acc_r   <= {(2*W){1'b0}};
              cnt_r   <= {CW{1'b0}};
              state_r <= MUL;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        MUL: begin
          acc_r <= acc_next_s;
          cnt_r <= cnt_r + CW'(1);
          if (cnt_r == CNT_LAST) begin
            result_r   <= sat_fn(mul_raw_s, mul_ovf_s);
            overflow_r <= mul_ovf_s;
            done_r     <= 1'b1;
            state_r    <= DONE;
          end else begin
            done_r <= 1'b0;
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.result   = result_r;
  assign bus.overflow = overflow_r;
endmodule

// File: tb/tb_fixed_arith_seq.sv
// Scoreboard bench: two 8.8 units (wrap and saturate) share stimulus, plus one 4.4 unit.
module tb_fixed_arith_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fixed_arith_seq_if #(.W(16)) b0 ();
  fixed_arith_seq_if #(.W(16)) b1 ();
  fixed_arith_seq_if #(.W(8))  b2 ();

  fixed_arith_seq #(.INT_W(8), .FRAC_W(8), .SATURATE(0)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
  fixed_arith_seq #(.INT_W(8), .FRAC_W(8), .SATURATE(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
  fixed_arith_seq #(.INT_W(4), .FRAC_W(4), .SATURATE(0)) dut2 (.clk(clk), .rst(rst), .bus(b2.slave));

  typedef struct {
    logic [15:0] res;
    logic        ovf;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference arithmetic on wide integers, then cut down to the unit's window.
  function automatic exp_t model(input int w, input int frac, input bit sat, input bit op,
                                 input logic [15:0] a, input logic [15:0] b);
    logic [32:0] p;
    logic [32:0] mask;
    exp_t e;
    mask = (33'd1 << w) - 33'd1;
    if (!op) begin
      p     = {17'd0, a} + {17'd0, b};
      e.ovf = p[w];
      e.res = 16'(p & mask);
    end else begin
      p     = {17'd0, a} * {17'd0, b};
      e.res = 16'((p >> frac) & mask);
      e.ovf = ((p >> (w + frac)) != 33'd0);
    end
    if (sat && e.ovf) e.res = 16'(mask);
    return e;
  endfunction

  // Output monitors: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (b0.done) begin
      if (q0.size() == 0) check_eq("spurious_done0", 32'd1, 32'd0);
      else begin
        e = q0.pop_front();
        check_eq("res0", {16'd0, b0.result}, {16'd0, e.res});
        check_eq("ovf0", {31'd0, b0.overflow}, {31'd0, e.ovf});
      end
    end
    if (b1.done) begin
      if (q1.size() == 0) check_eq("spurious_done1", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        check_eq("res1_sat", {16'd0, b1.result}, {16'd0, e.res});
        check_eq("ovf1_sat", {31'd0, b1.overflow}, {31'd0, e.ovf});
      end
    end
    if (b2.done) begin
      if (q2.size() == 0) check_eq("spurious_done2", 32'd1, 32'd0);
      else begin
        e = q2.pop_front();
        check_eq("res2_w8", {24'd0, b2.result}, {16'd0, e.res});
        check_eq("ovf2_w8", {31'd0, b2.overflow}, {31'd0, e.ovf});
      end
    end
  end

  task automatic drive16(input logic st, input logic op, input logic [15:0] a, input logic [15:0] b);
    b0.start = st; b0.op = op; b0.num1 = a; b0.num2 = b;
    b1.start = st; b1.op = op; b1.num1 = a; b1.num2 = b;
  endtask

  task automatic run16(input logic op, input logic [15:0] a, input logic [15:0] b, input bit glitch);
    int cyc;
    int busy_n;
    q0.push_back(model(16, 8, 1'b0, op, a, b));
    q1.push_back(model(16, 8, 1'b1, op, a, b));
    @(negedge clk);
    drive16(1'b1, op, a, b);
    @(negedge clk);
    b0.start = 1'b0; b1.start = 1'b0;
    cyc = 1;
    busy_n = b0.busy ? 1 : 0;
    while (!b0.done && cyc < 100) begin
      if (glitch && cyc == 3) drive16(1'b1, 1'b0, 16'hFFFF, 16'h1234);
      if (glitch && cyc == 4) begin b0.start = 1'b0; b1.start = 1'b0; end
      @(negedge clk);
      cyc++;
      if (b0.busy) busy_n++;
    end
    check_eq("latency", cyc, op ? 32'd17 : 32'd1);
    check_eq("busy_cycles", busy_n, op ? 32'd17 : 32'd1);
    check_eq("busy_at_done", {31'd0, b0.busy}, 32'd1);
    check_eq("done_pair", {31'd0, b1.done}, 32'd1);
    if (glitch) begin b0.start = 1'b1; b1.start = 1'b1; end
    @(negedge clk);
    b0.start = 1'b0; b1.start = 1'b0;
    check_eq("idle_busy", {31'd0, b0.busy}, 32'd0);
    check_eq("idle_done", {31'd0, b0.done}, 32'd0);
  endtask

  task automatic run8(input logic op, input logic [7:0] a, input logic [7:0] b);
    int cyc;
    q2.push_back(model(8, 4, 1'b0, op, {8'd0, a}, {8'd0, b}));
    @(negedge clk);
    b2.start = 1'b1; b2.op = op; b2.num1 = a; b2.num2 = b;
    @(negedge clk);
    b2.start = 1'b0;
    cyc = 1;
    while (!b2.done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("latency_w8", cyc, op ? 32'd9 : 32'd1);
    @(negedge clk);
  endtask

  initial begin
    drive16(1'b0, 1'b0, 16'h0000, 16'h0000);
    b2.start = 1'b0; b2.op = 1'b0; b2.num1 = 8'h00; b2.num2 = 8'h00;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", {31'd0, b0.busy}, 32'd0);
    check_eq("rst_done", {31'd0, b0.done}, 32'd0);
    check_eq("rst_result", {16'd0, b0.result}, 32'd0);
    check_eq("rst_ovf", {31'd0, b1.overflow}, 32'd0);
    rst = 1'b0;

    run16(1'b0, 16'h0180, 16'h0240, 1'b0);
    run16(1'b0, 16'hFF00, 16'h0200, 1'b0);
    run16(1'b1, 16'h0180, 16'h0200, 1'b1);
    run16(1'b1, 16'h1000, 16'h1000, 1'b0);
    run16(1'b1, 16'h0001, 16'h0001, 1'b0);
    run16(1'b1, 16'hFFFF, 16'hFFFF, 1'b0);
    for (int i = 0; i < 6; i++) begin
      run16(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 1'b0);
    end

    // Leave non-zero outputs, then abort a multiply five cycles in.
    run16(1'b0, 16'hFF00, 16'h0200, 1'b0);
    @(negedge clk);
    drive16(1'b1, 1'b1, 16'h0180, 16'h0200);
    @(negedge clk);
    b0.start = 1'b0; b1.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("abort_busy", {31'd0, b0.busy}, 32'd0);
    check_eq("abort_done", {31'd0, b0.done}, 32'd0);
    check_eq("abort_result", {16'd0, b0.result}, 32'd0);
    check_eq("abort_ovf", {31'd0, b0.overflow}, 32'd0);
    check_eq("abort_result_sat", {16'd0, b1.result}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("abort_no_busy", {31'd0, b0.busy}, 32'd0);
    run16(1'b0, 16'h0180, 16'h0240, 1'b0);

    run8(1'b1, 8'h18, 8'h20);
    run8(1'b0, 8'hF0, 8'h20);
    run8(1'b1, 8'hFF, 8'hFF);
    run8(1'b1, 8'h01, 8'h01);

    repeat (3) @(negedge clk);
    check_eq("q0_drained", q0.size(), 32'd0);
    check_eq("q1_drained", q1.size(), 32'd0);
    check_eq("q2_drained", q2.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fixed_arith_seq.md
Name: fixed_arith_seq

Overview:
Parametrised sequential unsigned fixed-point arithmetic unit. It performs addition (single cycle) or multiplication (shift-add, one multiplier bit per clock) on INT_W.FRAC_W operands. A start/busy/done handshake controls each operation, and an optional saturation mode is provided. It is the clocked, width-generic successor to the combinational 8.8 fixed adder/multiplier. Datapath blocks use it to trade area for latency.

Parameters:
INT_W, 8, integer bits per operand/result
FRAC_W, 8, fraction bits per operand/result; W = INT_W+FRAC_W (W >= 2)
SATURATE, 0, 0 = wrap/truncate on overflow; 1 = clamp result to all ones on overflow

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  request; sampled only in IDLE
op  in  1  0 = add, 1 = multiply; sampled with start
num1  in  W  operand / multiplicand, unsigned fixed point; latched at start
num2  in  W  operand / multiplier, unsigned fixed point; latched at start
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse; result/overflow valid from this cycle
result  out  W  registered result; held until next done
overflow  out  1  registered overflow flag; held until next done

Behaviour:
- Clock/reset: single clock domain clk. rst is asynchronous and active-high. It forces state IDLE, counter 0, accumulator 0, busy 0, done 0, result 0, overflow 0.
- States:
  - IDLE: on start=1, latch num1, num2 and op.
    - If op=0: compute sum, register result/overflow, go to DONE.
    - If op=1: clear 2W-bit accumulator and counter, go to MUL.
  - MUL: each edge, if latched num2[counter]=1, add (num1 << counter) into accumulator; increment counter. The edge processing counter = W-1 also registers result/overflow and goes to DONE.
  - DONE: done=1 for exactly this cycle; next edge goes to IDLE unconditionally.
- Latency, counting the start-sampling edge as edge 0:
  - add: done high in the cycle after edge 0.
  - multiply: done high in the cycle after edge W, i.e. W MUL cycles plus DONE.
  - Minimum spacing between accepted starts is 2 cycles for add and W+2 cycles for multiply.
- Add: sum = num1 + num2, computed at W+1 bits; overflow = bit W; raw result = sum[W-1:0].
- Multiply: product P is 2W bits. Raw result = P[W+FRAC_W-1 : FRAC_W], with fraction truncated and no rounding. overflow = OR of P[2W-1 : W+FRAC_W]; dropped low bits do not set overflow.
- Saturation: if SATURATE=1 and overflow=1, result = all ones. The overflow flag is set regardless of mode.
- Handshake: start is ignored while busy=1, including the DONE cycle. Operand or op changes during busy have no effect. start held high re-triggers only after returning to IDLE.
- done and busy are high together in DONE. Outside DONE, done is 0.
- Reset mid-operation: immediate abort to IDLE with all outputs 0. No done pulse is produced for the aborted operation.
- result/overflow change only on the DONE-entering edge or on reset.

Test Plan:
- Add, default params: 0x0180 + 0x0240 (1.5+2.25), op=0 -> done in cycle after start edge; result 0x03C0, overflow 0; busy high exactly 1 cycle.
- Add overflow: 0xFF00 + 0x0200 -> SATURATE=0: result 0x0100, overflow 1; SATURATE=1: result 0xFFFF, overflow 1.
- Multiply: 0x0180 × 0x0200 (1.5×2) -> result 0x0300, overflow 0; busy high 17 cycles; done after edge 16; start pulses during busy are ignored.
- Multiply overflow and truncation:
  - 0x1000 × 0x1000 (16×16) -> P = 0x01000000; SATURATE=0: result 0x0000, overflow 1; SATURATE=1: result 0xFFFF.
  - 0x0001 × 0x0001 -> result 0x0000, overflow 0.
- Reset abort: assert rst 5 cycles into a multiply -> busy, done, result and overflow all 0 immediately, no done pulse afterwards. A new add started after release completes correctly.
- Width check INT_W=4, FRAC_W=4: 0x18 × 0x20 (1.5×2) -> result 0x30 after edge 8; 0xF0 + 0x20 -> result 0x10, overflow 1.
